// File: rtl/pcpi_initiator.sv
// pcpi_initiator: PCPI master that issues {insn, rs1, rs2} commands to a coprocessor
// and returns {rd, wr, status}; one transaction outstanding at a time.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready       command channel (valid/ready), insn/rs1/rs2
//   o_rsp_*/i_rsp_ready       response channel (valid/ready), data/wr/status
//                             status: 00 OK, 01 UNCLAIMED, 10 TIMEOUT
//   o_pcpi_*                  PCPI request (valid, insn, rs1, rs2)
//   i_pcpi_*                  PCPI reply (wr, rd, wait, ready)
// Optional macro PCPI_INITIATOR_PERF_EN adds o_perf_latency and o_perf_unclaimed.
module pcpi_initiator #(
    parameter int unsigned CLAIM_TIMEOUT = 16,
    parameter int unsigned BUSY_TIMEOUT  = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_insn,
    input  logic [31:0] i_cmd_rs1,
    input  logic [31:0] i_cmd_rs2,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_wr,
    output logic [1:0]  o_rsp_status,
    output logic        o_pcpi_valid,
    output logic [31:0] o_pcpi_insn,
    output logic [31:0] o_pcpi_rs1,
    output logic [31:0] o_pcpi_rs2,
    input  logic        i_pcpi_wr,
    input  logic [31:0] i_pcpi_rd,
    input  logic        i_pcpi_wait,
    input  logic        i_pcpi_ready
`ifdef PCPI_INITIATOR_PERF_EN
    ,
    output logic [15:0] o_perf_latency,
    output logic [7:0]  o_perf_unclaimed
`endif
);
    localparam logic [7:0]  LP_CLAIM = 8'(CLAIM_TIMEOUT);
    localparam logic [15:0] LP_BUSY  = 16'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_claim_cnt;
    logic [15:0] r_busy_cnt;
    logic        w_accept, w_done, w_claim_hit, w_busy_hit, w_enter_resp;

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign w_accept     = o_cmd_ready && i_cmd_valid;
    // ready is only honoured while the request is on the bus, and it beats any timeout
    assign w_done       = ((r_state == S_ISSUE) || (r_state == S_BUSY)) && i_pcpi_ready;
    assign w_claim_hit  = (r_state == S_ISSUE) && !i_pcpi_ready && !i_pcpi_wait &&
                          (r_claim_cnt + 8'd1 == LP_CLAIM);
    assign w_busy_hit   = (r_state == S_BUSY) && !i_pcpi_ready && (LP_BUSY != 16'd0) &&
                          (r_busy_cnt + 16'd1 == LP_BUSY);
    assign w_enter_resp = w_done || w_claim_hit || w_busy_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_cmd_valid ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = w_enter_resp ? S_RESP : (i_pcpi_wait ? S_BUSY : S_ISSUE);
            S_BUSY:  w_next = w_enter_resp ? S_RESP : S_BUSY;
            S_RESP:  w_next = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pcpi_valid <= 1'b0;
            o_pcpi_insn  <= '0;
            o_pcpi_rs1   <= '0;
            o_pcpi_rs2   <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_wr     <= 1'b0;
            o_rsp_status <= 2'b00;
            r_claim_cnt  <= '0;
            r_busy_cnt   <= '0;
        end else begin
            if (w_accept) begin
                o_pcpi_valid <= 1'b1;
                o_pcpi_insn  <= i_cmd_insn;
                o_pcpi_rs1   <= i_cmd_rs1;
                o_pcpi_rs2   <= i_cmd_rs2;
                r_claim_cnt  <= '0;
                r_busy_cnt   <= '0;
            end
            if (r_state == S_ISSUE && !i_pcpi_ready && !i_pcpi_wait)
                r_claim_cnt <= r_claim_cnt + 8'd1;
            if (r_state == S_BUSY && !i_pcpi_ready)
                r_busy_cnt <= r_busy_cnt + 16'd1;
            if (w_enter_resp) begin
                o_pcpi_valid <= 1'b0;
                o_rsp_valid  <= 1'b1;
                o_rsp_data   <= w_done ? i_pcpi_rd : 32'd0;
                o_rsp_wr     <= w_done && i_pcpi_wr;
                o_rsp_status <= w_done ? 2'b00 : (w_claim_hit ? 2'b01 : 2'b10);
            end
            if (r_state == S_RESP && i_rsp_ready)
                o_rsp_valid <= 1'b0;
        end
    end

`ifdef PCPI_INITIATOR_PERF_EN
    logic [15:0] r_lat_cnt;
    logic [15:0] w_lat_inc;

    // counts request cycles including the current one, saturating
    assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lat_cnt        <= '0;
            o_perf_latency   <= '0;
            o_perf_unclaimed <= '0;
        end else begin
            if (w_accept)
                r_lat_cnt <= '0;
            else if (r_state == S_ISSUE || r_state == S_BUSY)
                r_lat_cnt <= w_lat_inc;
            if (w_enter_resp)
                o_perf_latency <= w_lat_inc;
            if ((w_claim_hit || w_busy_hit) && o_perf_unclaimed != 8'hFF)
                o_perf_unclaimed <= o_perf_unclaimed + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator: scoreboard bench for pcpi_initiator with directed PCPI coprocessor behaviour
module tb_pcpi_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
    logic        rsp_valid, rsp_ready, rsp_wr;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;

    logic        nb_cmd_valid, nb_cmd_ready, nb_rsp_valid, nb_rsp_wr, nb_pcpi_valid;
    logic [31:0] nb_rsp_data, nb_pcpi_insn, nb_pcpi_rs1, nb_pcpi_rs2;
    logic [1:0]  nb_rsp_status;
`ifdef PCPI_INITIATOR_PERF_EN
    logic [15:0] perf_latency, nb_perf_latency;
    logic [7:0]  perf_unclaimed, nb_perf_unclaimed;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        wr;
        logic [1:0]  st;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pcpi_initiator #(.CLAIM_TIMEOUT(16), .BUSY_TIMEOUT(8)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_insn(cmd_insn), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_wr(rsp_wr), .o_rsp_status(rsp_status),
        .o_pcpi_valid(pcpi_valid), .o_pcpi_insn(pcpi_insn),
        .o_pcpi_rs1(pcpi_rs1), .o_pcpi_rs2(pcpi_rs2),
        .i_pcpi_wr(pcpi_wr), .i_pcpi_rd(pcpi_rd),
        .i_pcpi_wait(pcpi_wait), .i_pcpi_ready(pcpi_ready)
`ifdef PCPI_INITIATOR_PERF_EN
        , .o_perf_latency(perf_latency), .o_perf_unclaimed(perf_unclaimed)
`endif
    );

    pcpi_initiator #(.CLAIM_TIMEOUT(16), .BUSY_TIMEOUT(0)) u_nobusy (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(nb_cmd_valid), .o_cmd_ready(nb_cmd_ready),
        .i_cmd_insn(32'h0000_000B), .i_cmd_rs1(32'd1), .i_cmd_rs2(32'd2),
        .o_rsp_valid(nb_rsp_valid), .i_rsp_ready(1'b1),
        .o_rsp_data(nb_rsp_data), .o_rsp_wr(nb_rsp_wr), .o_rsp_status(nb_rsp_status),
        .o_pcpi_valid(nb_pcpi_valid), .o_pcpi_insn(nb_pcpi_insn),
        .o_pcpi_rs1(nb_pcpi_rs1), .o_pcpi_rs2(nb_pcpi_rs2),
        .i_pcpi_wr(1'b0), .i_pcpi_rd(32'd0),
        .i_pcpi_wait(1'b1), .i_pcpi_ready(1'b0)
`ifdef PCPI_INITIATOR_PERF_EN
        , .o_perf_latency(nb_perf_latency), .o_perf_unclaimed(nb_perf_unclaimed)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: a response is consumed on the edge following valid && ready
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {rsp_data[28:0], rsp_wr, rsp_status}, 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, e.wr});
                chk("rsp_status", {30'd0, rsp_status}, {30'd0, e.st});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        cmd_insn  = insn;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_valid = 1'b1;
        chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        rsp_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        nb_cmd_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_status", {30'd0, rsp_status}, 32'd0);
        chk("reset_pcpi_insn", pcpi_insn, 32'd0);

        // wait three cycles, then complete with rd=35
        exp_q.push_back('{d: 32'd35, wr: 1'b1, st: 2'b00});
        send(32'h0200_000B, 32'd5, 32'd7);
        chk("t1_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
        chk("t1_pcpi_insn", pcpi_insn, 32'h0200_000B);
        chk("t1_pcpi_rs1", pcpi_rs1, 32'd5);
        chk("t1_pcpi_rs2", pcpi_rs2, 32'd7);
        pcpi_wait = 1'b1;
        tick(); tick(); tick();
        pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_rd = 32'd35; pcpi_wr = 1'b1;
        tick();
        pcpi_ready = 1'b0; pcpi_rd = 32'h1111_1111; pcpi_wr = 1'b0;
        chk("t1_pcpi_valid_low", {31'd0, pcpi_valid}, 32'd0);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
`ifdef PCPI_INITIATOR_PERF_EN
        chk("t1_perf_latency", {16'd0, perf_latency}, 32'd4);
`endif
        tick();
        chk("t1_insn_retained", pcpi_insn, 32'h0200_000B);

        // unclaimed: request must stay up exactly 16 cycles
        exp_q.push_back('{d: 32'd0, wr: 1'b0, st: 2'b01});
        pcpi_rd = 32'hDEAD_BEEF; pcpi_wr = 1'b1;
        send(32'h1234_000B, 32'd1, 32'd2);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!pcpi_valid) break;
            n++;
            tick();
        end
        chk("t2_valid_cycles", n, 32'd16);
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        tick();

        // busy timeout after 8 BUSY cycles (1 ISSUE + 8 BUSY = 9 valid cycles)
        exp_q.push_back('{d: 32'd0, wr: 1'b0, st: 2'b10});
        send(32'h5555_000B, 32'd3, 32'd4);
        pcpi_wait = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!pcpi_valid) break;
            n++;
            tick();
        end
        chk("t3_valid_cycles", n, 32'd9);
        pcpi_wait = 1'b0;
        tick();
        pcpi_wr = 1'b0;

        // ready on first valid cycle, response held for 5 cycles
        rsp_ready = 1'b0;
        exp_q.push_back('{d: 32'hCAFE_F00D, wr: 1'b0, st: 2'b00});
        send(32'h0A0A_000B, 32'd9, 32'd9);
        pcpi_ready = 1'b1; pcpi_rd = 32'hCAFE_F00D;
        tick();
        pcpi_ready = 1'b0;
        chk("t4_rsp_valid_n2", {31'd0, rsp_valid}, 32'd1);
        chk("t4_pcpi_valid_n2", {31'd0, pcpi_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            pcpi_rd = 32'h100 + 32'(i);
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_data", rsp_data, 32'hCAFE_F00D);
            chk("t4_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        // back-to-back commands every 3 cycles
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{d: 32'hA000 + 32'(k), wr: k[0], st: 2'b00});
            send(32'h0000_000B + 32'(k << 12), 32'(k), 32'(k));
            pcpi_ready = 1'b1; pcpi_rd = 32'hA000 + 32'(k); pcpi_wr = k[0];
            tick();
            pcpi_ready = 1'b0; pcpi_wr = 1'b0;
            tick();
        end

        // ready in the very cycle the claim counter would expire
        exp_q.push_back('{d: 32'd77, wr: 1'b1, st: 2'b00});
        send(32'h0707_000B, 32'd7, 32'd7);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_valid_at_16", {31'd0, pcpi_valid}, 32'd1);
        pcpi_ready = 1'b1; pcpi_rd = 32'd77; pcpi_wr = 1'b1;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("t5_pcpi_valid_low", {31'd0, pcpi_valid}, 32'd0);
        tick();

        // reset during BUSY, then stray ready in IDLE
        send(32'h0909_000B, 32'd1, 32'd1);
        pcpi_wait = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; pcpi_wait = 1'b0;
        chk("t6_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        pcpi_ready = 1'b1; pcpi_rd = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        pcpi_ready = 1'b0;

        // BUSY_TIMEOUT=0 instance holds BUSY indefinitely
        nb_cmd_valid = 1'b1;
        tick();
        nb_cmd_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (nb_rsp_valid !== 1'b0 || nb_pcpi_valid !== 1'b1) bad++;
            tick();
        end
        chk("t7_busy_hold_violations", bad, 32'd0);

        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
